crossbar_issue_sched: RTL

CROSSBAR_ISSUE_SCHED -- requirements
Module: crossbar_issue_sched

---
 rtl/crossbar_issue_sched_if.sv | 26 ++
 rtl/crossbar_issue_sched.sv | 75 +++++++
 2 files changed

// File: rtl/crossbar_issue_sched_if.sv
// crossbar_issue_sched_if: push channels, matched-pair output, flush and stall count for the issue scheduler.
interface crossbar_issue_sched_if #(
  parameter int PHV_LEN     = 2304,
  parameter int ACT_TOT_LEN = 4160
);
  logic [PHV_LEN-1:0]     phv_in;
  logic                   phv_in_valid;
  logic                   phv_ready_out;
  logic [ACT_TOT_LEN-1:0] action_in;
  logic                   action_in_valid;
  logic                   action_ready_out;
  logic [PHV_LEN-1:0]     phv_out;
  logic [ACT_TOT_LEN-1:0] action_out;
  logic                   pair_valid;
  logic                   ready_in;
  logic                   flush;
  logic [15:0]            stall_cnt;
  modport master (
    output phv_in, phv_in_valid, action_in, action_in_valid, ready_in, flush,
    input  phv_ready_out, action_ready_out, phv_out, action_out, pair_valid, stall_cnt
  );
  modport slave (
    input  phv_in, phv_in_valid, action_in, action_in_valid, ready_in, flush,
    output phv_ready_out, action_ready_out, phv_out, action_out, pair_valid, stall_cnt
  );
endinterface

// File: rtl/crossbar_issue_sched.sv
// crossbar_issue_sched: pairs queued PHVs with queued actions in order and issues them to the crossbar.
// Define SCHED_STALL_CNT_EN to build the saturating starvation counter; otherwise stall_cnt reads 0.
module crossbar_issue_sched #(
  parameter int PHV_LEN     = 2304,
  parameter int ACT_TOT_LEN = 4160,
  parameter int FIFO_DEPTH  = 4
) (
  input logic clk,
  input logic rst,
  crossbar_issue_sched_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [PHV_LEN-1:0]     phv_mem [FIFO_DEPTH];
  logic [ACT_TOT_LEN-1:0] act_mem [FIFO_DEPTH];
  logic [AW-1:0] p_wr, p_rd, a_wr, a_rd;
  logic [CW-1:0] p_cnt, a_cnt;
  logic p_push, a_push, issue;
  assign bus.phv_ready_out    = !rst && (p_cnt < CW'(FIFO_DEPTH));
  assign bus.action_ready_out = !rst && (a_cnt < CW'(FIFO_DEPTH));
  assign p_push = bus.phv_in_valid && bus.phv_ready_out && !bus.flush;
  assign a_push = bus.action_in_valid && bus.action_ready_out && !bus.flush;
  assign issue  = (p_cnt != '0) && (a_cnt != '0) && (!bus.pair_valid || bus.ready_in) && !bus.flush;
  // storage is never reset; the counters alone decide which slots are live
  always_ff @(posedge clk) begin
    if (p_push) phv_mem[p_wr] <= bus.phv_in;
    if (a_push) act_mem[a_wr] <= bus.action_in;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_wr <= '0;
      p_rd <= '0;
      a_wr <= '0;
      a_rd <= '0;
      p_cnt <= '0;
      a_cnt <= '0;
      bus.pair_valid <= 1'b0;
      bus.phv_out <= '0;
      bus.action_out <= '0;
    end else if (bus.flush) begin
      p_wr <= '0;
      p_rd <= '0;
      a_wr <= '0;
      a_rd <= '0;
      p_cnt <= '0;
      a_cnt <= '0;
      bus.pair_valid <= 1'b0;
    end else begin
      p_wr <= p_wr + AW'(p_push);
      a_wr <= a_wr + AW'(a_push);
      p_rd <= p_rd + AW'(issue);
      a_rd <= a_rd + AW'(issue);
      p_cnt <= p_cnt + CW'(p_push) - CW'(issue);
      a_cnt <= a_cnt + CW'(a_push) - CW'(issue);
      if (issue) begin
        bus.phv_out <= phv_mem[p_rd];
        bus.action_out <= act_mem[a_rd];
        bus.pair_valid <= 1'b1;
      end else if (bus.ready_in) begin
        bus.pair_valid <= 1'b0;
      end
    end
  end
`ifdef SCHED_STALL_CNT_EN
  logic [15:0] stall;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall <= '0;
    else if (bus.flush) stall <= '0;
    else if (((p_cnt == '0) != (a_cnt == '0)) && (stall != 16'hFFFF)) stall <= stall + 16'd1;
  end
  assign bus.stall_cnt = stall;
`else
  assign bus.stall_cnt = 16'h0000;
`endif
endmodule
